// File: rtl/sap1_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sap1_disp_pkg
// Purpose  : Shared types and constants for the SAP-1 output display block:
//            controller state encoding, 7-segment patterns and blank codes.
// Revision : 1.0 - initial release
// ============================================================================
package sap1_disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Active-low gfedcba patterns, indexed by decimal digit.
  localparam logic [6:0] SEG_LUT [10] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [2:0] AN_OFF    = 3'b111;

  // Codes above 9 cannot be produced by the converter; they show blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    pattern = SEG_BLANK;
    if (digit <= 4'd9) pattern = SEG_LUT[digit];
    return pattern;
  endfunction

endpackage : sap1_disp_pkg
`default_nettype wire

// File: rtl/bin2bcd8_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd8_seq
// Purpose  : Sequential 8-bit binary to 3-digit BCD converter using the
//            shift-add-3 method, one shift per clock, eight clocks per value.
//            start loads a value; done is high in the cycle whose edge does
//            the final shift, so bcd holds the result from the next cycle.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd8_seq (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  // {hundreds, tens, ones, binary}
  logic [19:0] shreg;
  logic [19:0] shreg_adj;
  logic [2:0]  cnt;
  logic        active;

  // Pre-shift correction: any BCD nibble of 5 or more gets 3 added.
  always_comb begin
    shreg_adj = shreg;
    if (shreg[11:8]  >= 4'd5) shreg_adj[11:8]  = shreg[11:8]  + 4'd3;
    if (shreg[15:12] >= 4'd5) shreg_adj[15:12] = shreg[15:12] + 4'd3;
    if (shreg[19:16] >= 4'd5) shreg_adj[19:16] = shreg[19:16] + 4'd3;
  end

  // Load on start, otherwise correct-and-shift until eight shifts are done.
  always_ff @(posedge clk) begin
    if (!clr) begin
      shreg  <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      shreg  <= {12'b0, bin};
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      shreg <= {shreg_adj[18:0], 1'b0};
      cnt   <= cnt + 3'd1;
      if (cnt == 3'd7) active <= 1'b0;
    end
  end

  assign done = active && (cnt == 3'd7);
  assign bcd  = shreg[19:8];

endmodule : bin2bcd8_seq
`default_nettype wire

// File: rtl/sap1_out_display.sv
`default_nettype none
// ============================================================================
// Module   : sap1_out_display
// Purpose  : Captures each SAP-1 output register load, converts it to BCD and
//            drives a 3-digit multiplexed common-anode 7-segment display.
//            Loads arriving during a conversion go to a one-deep latest-wins
//            pending slot.
// Options  : SAP1_DISP_BLANK_EN - leading-zero blanking of hundreds/tens.
// Revision : 1.0 - initial release
// ============================================================================
module sap1_out_display
  import sap1_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 1000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] out_val,
  input  logic       out_ld,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       busy
);

  localparam int              RW       = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0]   REF_LAST = RW'(REFRESH_DIV - 1);

  state_t         state;
  logic [7:0]     pend;
  logic           pend_vld;
  logic           conv_start;
  logic [7:0]     conv_in;
  logic           conv_done;
  logic [11:0]    conv_bcd;
  logic [3:0]     dig_hun;
  logic [3:0]     dig_ten;
  logic [3:0]     dig_one;
  logic [RW-1:0]  ref_cnt;
  logic [1:0]     idx;
  logic [3:0]     cur_digit;

  // A fresh load takes priority over the pending slot when both are present.
  assign conv_start = (state == IDLE) && (out_ld || pend_vld);
  assign conv_in    = out_ld ? out_val : pend;

  bin2bcd8_seq u_bin2bcd (
    .clk   (clk),
    .clr   (clr),
    .start (conv_start),
    .bin   (conv_in),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Controller: sequences conversions, owns the pending slot and display digits.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= IDLE;
      busy     <= 1'b0;
      pend     <= '0;
      pend_vld <= 1'b0;
      dig_hun  <= '0;
      dig_ten  <= '0;
      dig_one  <= '0;
    end else begin
      if ((state != IDLE) && out_ld) begin
        pend     <= out_val;
        pend_vld <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (conv_start) begin
            state    <= CONV;
            busy     <= 1'b1;
            pend_vld <= 1'b0;
          end
        end
        CONV: begin
          if (conv_done) state <= COMMIT;
        end
        COMMIT: begin
          dig_hun <= conv_bcd[11:8];
          dig_ten <= conv_bcd[7:4];
          dig_one <= conv_bcd[3:0];
          state   <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running digit scan, independent of conversions.
  always_ff @(posedge clk) begin
    if (!clr) begin
      ref_cnt <= '0;
      idx     <= '0;
    end else if (ref_cnt == REF_LAST) begin
      ref_cnt <= '0;
      idx     <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Select the scanned digit, decode it, and apply optional blanking.
  always_comb begin
    case (idx)
      2'd1:    cur_digit = dig_ten;
      2'd2:    cur_digit = dig_hun;
      default: cur_digit = dig_one;
    endcase
    seg = seg_decode(cur_digit);
`ifdef SAP1_DISP_BLANK_EN
    if ((idx == 2'd2) && (dig_hun == 4'd0)) seg = SEG_BLANK;
    if ((idx == 2'd1) && (dig_hun == 4'd0) && (dig_ten == 4'd0)) seg = SEG_BLANK;
`else
    seg = seg;
`endif
    an = AN_OFF & ~(3'b001 << idx);
  end

endmodule : sap1_out_display
`default_nettype wire

// File: doc/sap1_out_display.md
# sap1_out_display

Downstream consumer of the SAP-1 computer's 8-bit output register. Each value the output register loads is captured, converted to three BCD digits with a sequential shift-add-3 converter, and shown on a time-multiplexed 3-digit common-anode 7-segment display. Values loaded while a conversion is in progress are buffered in a one-deep, latest-wins slot and are never lost mid-stream.

## Interface
- REFRESH_DIV, 1000, clk cycles each digit is lit; must be ≥2.
- clk  in  1  system clock, rising edge.
- clr  in  1  reset; synchronous, active-low.
- out_val  in  8  SAP-1 output register value, unsigned.
- out_ld  in  1  high for one or more cycles when the output register loads; each sampled-high cycle is one load.
- seg  out  7  segments gfedcba, active-low.
- an  out  3  digit enables, active-low one-hot; bit0 ones, bit1 tens, bit2 hundreds.
- busy  out  1  conversion in progress.

## Operation
- FSM states:
  - IDLE: start when out_ld is high, or when pend_vld is set. If both hold, out_ld wins and pend_vld clears. Start loads shift register {12'b0, value}, cnt=0, and moves to CONV.
  - CONV: 8 cycles. Each cycle, add 3 to every BCD nibble ≥5, then shift the whole register left by 1. After the 8th shift, move to COMMIT.
  - COMMIT: copy hundreds/tens/ones nibbles into the display registers, then return to IDLE.
- Pending slot: out_ld while not IDLE stores out_val into pend and sets pend_vld. A later load overwrites it (latest wins). The slot clears when its conversion starts.
- Scan: refresh counter runs 0..REFRESH_DIV-1. On wrap, the digit index advances 0→1→2→0. an = ~(1<<idx). seg = decode(display digit[idx]).
- Decode: 0–9 use standard active-low patterns (0 = 7'b1000000). Nibble codes above 9 cannot occur.
- Reset (clr low at an edge) forces the following, including mid-conversion:
  - state IDLE, pend_vld=0, busy=0;
  - display digits 0,0,0; refresh counter 0; idx 0;
  - seg=7'b1000000, an=3'b110.
  - Any in-flight or pending value is discarded.

## Timing
- out_ld sampled at edge E0 in IDLE: busy=1 after E0; CONV shifts at E1..E8; COMMIT at E9; display updated and busy=0 after E9. Latency is 9 cycles; the new value is visible on the currently scanned digit from cycle E9+1.
- A pending value starts at the first IDLE edge after COMMIT (E10), so back-to-back conversions are 10 cycles apart.
- busy is registered and is high exactly in CONV and COMMIT.
- The scan counter is independent of the FSM; a display update never resets the scan.
- out_val is sampled only on edges where out_ld is high.

## Configuration
- SAP1_DISP_BLANK_EN defined: leading-zero blanking. Hundreds shows blank (seg=7'b1111111) when it is 0. Tens shows blank when both hundreds and tens are 0. Ones is never blanked.
- Undefined: all three digits always shown, e.g. 005.
- Blanking is applied at decode time only; the display registers are unaffected.

## Structure
- Package sap1_disp_pkg holds:
  - state enum {IDLE, CONV, COMMIT};
  - SEG_LUT constant array for digits 0–9;
  - SEG_BLANK = 7'b1111111;
  - AN_OFF = 3'b111.
- Sub-module bin2bcd8_seq holds the shift register, cnt, and add-3 logic. It has a start/done handshake and a 12-bit bcd output. The top holds the FSM, pending slot, scan, and decode.
- Refresh counter width is $clog2(REFRESH_DIV).

## Test plan
- Reset: hold clr low 2 cycles → seg=7'b1000000, an=3'b110, busy=0; scan then advances every REFRESH_DIV cycles.
- REFRESH_DIV=4, out_val=8'd255 pulsed once → busy high exactly 9 cycles. Scanning yields ones=5 (7'b0010010), tens=5, hundreds=2 (7'b0100100). an sequence is 110,101,011, each held 4 cycles.
- Load 8'd100; during busy, load 8'd7 then 8'd42 → display shows 1,0,0, then 0,4,2 starting 10 cycles after the first commit; 7 is never displayed.
- SAP1_DISP_BLANK_EN, load 8'd5 → hundreds and tens seg=7'b1111111, ones=7'b0010010. Load 8'd0 → ones shows 0.
- Load 8'd200 and assert clr at E4 (mid-CONV) → after reset the display shows 000, busy=0, pend_vld=0, and no commit follows.
- out_ld high in the same IDLE cycle that pend_vld is set → the new out_ld value is converted and the pending value is dropped.
